lab_1_tdm_demux: RTL

Receive-side time-division demultiplexer that undoes the 4:1 two-bit lane multiplexer. A serial stream of WIDTH-bit symbols, with the slot-0 symbol flagged by `frame_start`, is collected slot by slot into a shadow buffer. Each complete four-slot frame is then presented in parallel on outputs `a`, `b`, `c` and `d`. The block sits at the far end of the shared 2-bit link and feeds downstream parallel logic with a one-cycle `out_valid` strobe.

---
 rtl/lab_1_tdm_demux.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lab_1_tdm_demux.sv
// ---------------------------------------------------------------------------
// lab_1_tdm_demux
//
// Receive-side 4:1 time-division demultiplexer. Serial WIDTH-bit symbols are
// collected slot by slot (slot 0 flagged by frame_start) into shadow
// registers; when slot 3 arrives the whole frame is published in parallel on
// a..d together with a one-cycle out_valid strobe. A partial frame is thrown
// away (one-cycle frame_err) when a new frame_start interrupts it or when the
// link stays silent for TIMEOUT cycles mid-frame.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   din          serial symbol
//   din_valid    din carries a symbol this cycle
//   frame_start  din is slot 0 (only meaningful with din_valid)
//   a,b,c,d      last complete frame, slots 0..3
//   out_valid    pulse: a..d were just updated
//   s1,s0        next expected slot index, 00 while idle
//   busy         a frame is being collected
//   frame_err    pulse: a partial frame was discarded
// ---------------------------------------------------------------------------
module lab_1_tdm_demux #(
    parameter int WIDTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic             s1,
    output logic             s0,
    output logic             busy,
    output logic             frame_err
);

    // Gap counter only ever needs to reach TIMEOUT-1.
    localparam int GW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int GAP_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];
    localparam logic [GW-1:0] GAP_ONE  = {{(GW-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_c_q, sh_c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        gap_cnt_d   = gap_cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_c_d      = sh_c_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                gap_cnt_d = '0;
                // Symbols without frame_start are simply ignored here.
                if (din_valid && frame_start) begin
                    sh_a_d  = din;
                    slot_d  = 2'd1;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (din_valid) begin
                    // Any accepted symbol restarts the silence window, which
                    // also gives it priority over a timeout on this cycle.
                    gap_cnt_d = '0;
                    if (frame_start) begin
                        // Resync: drop the partial frame, start a new one.
                        frame_err_d = 1'b1;
                        sh_a_d      = din;
                        slot_d      = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                sh_b_d = din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh_c_d = din;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                a_d         = sh_a_q;
                                b_d         = sh_b_q;
                                c_d         = sh_c_q;
                                d_d         = din;
                                out_valid_d = 1'b1;
                                slot_d      = 2'd0;
                                state_d     = IDLE;
                            end
                            default: begin
                                // Slot 0 never occurs while collecting;
                                // recover to idle if it somehow does.
                                slot_d  = 2'd0;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end else if (TIMEOUT != 0) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        // This is the TIMEOUT-th silent cycle in a row.
                        frame_err_d = 1'b1;
                        slot_d      = 2'd0;
                        gap_cnt_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                slot_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= 2'd0;
            gap_cnt_q   <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_c_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            gap_cnt_q   <= gap_cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_c_q      <= sh_c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign s1        = slot_q[1];
    assign s0        = slot_q[0];
    assign busy      = (state_q == COLLECT);

endmodule
